// File: rtl/regfile_tagged_pkg.sv
// regfile_tagged_pkg: constants shared by the tagged register file.
//   - Default geometry (data width, register count, port counts, tag width).
//   - Shared zero/enable constants: ZeroWord, ZeroRegAddr, ZeroTag, Enable, Disable.
package regfile_tagged_pkg;

  localparam int XlenDef = 32;
  localparam int NregDef = 32;
  localparam int NrdDef  = 2;
  localparam int NcmDef  = 2;
  localparam int TagwDef = 4;
  localparam int AwDef   = $clog2(NregDef);

  localparam logic [XlenDef-1:0] ZeroWord    = '0;
  localparam logic [AwDef-1:0]   ZeroRegAddr = '0;
  localparam logic [TagwDef-1:0] ZeroTag     = '0;
  localparam logic               Enable      = 1'b1;
  localparam logic               Disable     = 1'b0;

endpackage

// File: rtl/regfile_tagged_if.sv
// regfile_tagged_if: bundle of read, dispatch-rename, commit and flush signals
// between the pipeline (master) and the tagged register file (slave).
//   rd_en/rd_addr        -> read request per port (AW bits per port)
//   rd_data/rd_busy/rd_tag <- combinational read result per port
//   ds_valid/ds_addr/ds_tag -> rename of one destination
//   cm_valid/cm_addr/cm_tag/cm_data -> NCM commit ports, higher index younger
//   flush                -> clear all rename state
// Signalling: there is no ready/backpressure. Every *_valid / *_en / flush
// input is a qualifier sampled at every rising clock edge; when it is low the
// accompanying address/tag/data fields are don't-care.
interface regfile_tagged_if
  import regfile_tagged_pkg::*;
#(
  parameter int XLEN = XlenDef,
  parameter int NREG = NregDef,
  parameter int NRD  = NrdDef,
  parameter int NCM  = NcmDef,
  parameter int TAGW = TagwDef
);
  localparam int AW = $clog2(NREG);

  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NRD*TAGW-1:0] rd_tag;

  logic                ds_valid;
  logic [AW-1:0]       ds_addr;
  logic [TAGW-1:0]     ds_tag;

  logic [NCM-1:0]      cm_valid;
  logic [NCM*AW-1:0]   cm_addr;
  logic [NCM*TAGW-1:0] cm_tag;
  logic [NCM*XLEN-1:0] cm_data;

  logic                flush;

  modport master (
    output rd_en, rd_addr, ds_valid, ds_addr, ds_tag,
           cm_valid, cm_addr, cm_tag, cm_data, flush,
    input  rd_data, rd_busy, rd_tag
  );

  modport slave (
    input  rd_en, rd_addr, ds_valid, ds_addr, ds_tag,
           cm_valid, cm_addr, cm_tag, cm_data, flush,
    output rd_data, rd_busy, rd_tag
  );

endinterface

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one combinational read port of the tagged register file.
// Resolves same-cycle commit bypass and busy clearing for one address.
//   en, addr                 : read request
//   st_data, st_busy, st_tag : stored state of the addressed register
//   cm_valid/cm_addr/cm_tag/cm_data : all commit ports of this cycle
//   data, busy, tag          : resolved read result
module regfile_rd_port
  import regfile_tagged_pkg::*;
#(
  parameter int XLEN = XlenDef,
  parameter int NCM  = NcmDef,
  parameter int TAGW = TagwDef,
  parameter int AW   = AwDef
) (
  input  logic                en,
  input  logic [AW-1:0]       addr,
  input  logic [XLEN-1:0]     st_data,
  input  logic                st_busy,
  input  logic [TAGW-1:0]     st_tag,
  input  logic [NCM-1:0]      cm_valid,
  input  logic [NCM*AW-1:0]   cm_addr,
  input  logic [NCM*TAGW-1:0] cm_tag,
  input  logic [NCM*XLEN-1:0] cm_data,
  output logic [XLEN-1:0]     data,
  output logic                busy,
  output logic [TAGW-1:0]     tag
);

  logic clr;

  always_comb begin
    data = st_data;
    clr  = Disable;
    // Ascending scan: the youngest (highest-index) matching commit is the
    // last assignment and therefore supplies the data.
    for (int i = 0; i < NCM; i++) begin
      if (cm_valid[i] && cm_addr[i*AW +: AW] == addr) begin
        data = cm_data[i*XLEN +: XLEN];
        if (cm_tag[i*TAGW +: TAGW] == st_tag) clr = Enable;
      end
    end
    busy = st_busy & ~clr;
    tag  = busy ? st_tag : ZeroTag;
    if (!en || addr == ZeroRegAddr) begin
      data = ZeroWord;
      busy = Disable;
      tag  = ZeroTag;
    end
  end

endmodule

// File: rtl/regfile_tagged.sv
// regfile_tagged: architectural register file with per-register rename state
// {data, busy, tag}. Register 0 is hardwired to zero and never renamed.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset, clears data, busy and tag
//   bus  : regfile_tagged_if slave (reads, dispatch rename, commits, flush)
module regfile_tagged
  import regfile_tagged_pkg::*;
#(
  parameter int XLEN = XlenDef,
  parameter int NREG = NregDef,
  parameter int NRD  = NrdDef,
  parameter int NCM  = NcmDef,
  parameter int TAGW = TagwDef
) (
  input  logic           clk,
  input  logic           rst,
  regfile_tagged_if.slave bus
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] mem_data [NREG];
  logic [NREG-1:0] mem_busy;
  logic [TAGW-1:0] mem_tag  [NREG];

  logic [XLEN-1:0] nxt_data [NREG];
  logic [NREG-1:0] nxt_busy;
  logic [TAGW-1:0] nxt_tag  [NREG];
  logic [NREG-1:0] cm_clr;

  // While reset is held, the commit bypass is suppressed so every read
  // port shows zero regardless of what the commit inputs carry.
  logic [NCM-1:0] cm_live;
  assign cm_live = rst ? bus.cm_valid : '0;

  // Next-state: commit writes data; rename state priority is
  // flush > dispatch > tag-matching commit.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      nxt_data[r] = mem_data[r];
      nxt_busy[r] = mem_busy[r];
      nxt_tag[r]  = mem_tag[r];
      cm_clr[r]   = Disable;
      for (int i = 0; i < NCM; i++) begin
        if (bus.cm_valid[i] && bus.cm_addr[i*AW +: AW] == AW'(r)) begin
          nxt_data[r] = bus.cm_data[i*XLEN +: XLEN];
          if (bus.cm_tag[i*TAGW +: TAGW] == mem_tag[r]) cm_clr[r] = Enable;
        end
      end
      if (bus.flush) begin
        nxt_busy[r] = Disable;
        nxt_tag[r]  = ZeroTag;
      end else if (bus.ds_valid && bus.ds_addr == AW'(r)) begin
        nxt_busy[r] = Enable;
        nxt_tag[r]  = bus.ds_tag;
      end else if (cm_clr[r]) begin
        nxt_busy[r] = Disable;
        nxt_tag[r]  = ZeroTag;
      end
      if (r == 0) begin
        nxt_data[r] = ZeroWord;
        nxt_busy[r] = Disable;
        nxt_tag[r]  = ZeroTag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        mem_data[r] <= ZeroWord;
        mem_tag[r]  <= ZeroTag;
      end
      mem_busy <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        mem_data[r] <= nxt_data[r];
        mem_tag[r]  <= nxt_tag[r];
      end
      mem_busy <= nxt_busy;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy;
    logic [TAGW-1:0] tag;

    assign addr = bus.rd_addr[p*AW +: AW];

    regfile_rd_port #(
      .XLEN (XLEN),
      .NCM  (NCM),
      .TAGW (TAGW),
      .AW   (AW)
    ) u_rd_port (
      .en       (bus.rd_en[p]),
      .addr     (addr),
      .st_data  (mem_data[addr]),
      .st_busy  (mem_busy[addr]),
      .st_tag   (mem_tag[addr]),
      .cm_valid (cm_live),
      .cm_addr  (bus.cm_addr),
      .cm_tag   (bus.cm_tag),
      .cm_data  (bus.cm_data),
      .data     (data),
      .busy     (busy),
      .tag      (tag)
    );

    assign bus.rd_data[p*XLEN +: XLEN] = data;
    assign bus.rd_busy[p]              = busy;
    assign bus.rd_tag[p*TAGW +: TAGW]  = tag;
  end

endmodule

// File: tb/tb_regfile_tagged.sv
// tb_regfile_tagged: directed bench for regfile_tagged with hand-computed
// expectations for reads, bypass, rename, commit priority, flush and reset.
module tb_regfile_tagged;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NCM  = 2;
  localparam int TAGW = 4;
  localparam int AW   = 5;

  logic clk;
  logic rst;

  int n_cmp  = 0;
  int n_fail = 0;

  regfile_tagged_if #(
    .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NCM(NCM), .TAGW(TAGW)
  ) bus ();

  regfile_tagged #(
    .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NCM(NCM), .TAGW(TAGW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic idle();
    bus.rd_en    = '0;
    bus.rd_addr  = '0;
    bus.ds_valid = 1'b0;
    bus.ds_addr  = '0;
    bus.ds_tag   = '0;
    bus.cm_valid = '0;
    bus.cm_addr  = '0;
    bus.cm_tag   = '0;
    bus.cm_data  = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    bus.rd_en[p]             = 1'b1;
    bus.rd_addr[p*AW +: AW]  = a;
  endtask

  task automatic cm(input int i, input logic [AW-1:0] a,
                    input logic [TAGW-1:0] t, input logic [XLEN-1:0] d);
    bus.cm_valid[i]              = 1'b1;
    bus.cm_addr[i*AW +: AW]      = a;
    bus.cm_tag[i*TAGW +: TAGW]   = t;
    bus.cm_data[i*XLEN +: XLEN]  = d;
  endtask

  task automatic cm_off();
    bus.cm_valid = '0;
  endtask

  task automatic ds(input logic [AW-1:0] a, input logic [TAGW-1:0] t);
    bus.ds_valid = 1'b1;
    bus.ds_addr  = a;
    bus.ds_tag   = t;
  endtask

  // Advance past one rising edge; inputs change 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // comparison helper
  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic chk_port(input string name, input int p, input logic [XLEN-1:0] d,
                          input logic b, input logic [TAGW-1:0] t);
    #1;
    chk({name, "_data"}, 64'(bus.rd_data[p*XLEN +: XLEN]), 64'(d));
    chk({name, "_busy"}, 64'(bus.rd_busy[p]), 64'(b));
    chk({name, "_tag"},  64'(bus.rd_tag[p*TAGW +: TAGW]), 64'(t));
  endtask

  initial begin
    rst = 1'b0;
    idle();
    rd(0, 5'd5);
    rd(1, 5'd5);
    // commit inputs active during reset must not leak through the bypass
    cm(0, 5'd5, 4'd3, 32'h1234_5678);
    #3;
    chk_port("reset_p0", 0, 32'h0, 1'b0, 4'h0);
    chk_port("reset_p1", 1, 32'h0, 1'b0, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    cm_off();
    tick();

    // x5 read, then commit with same-cycle bypass
    chk_port("x5_empty", 0, 32'h0, 1'b0, 4'h0);
    cm(0, 5'd5, 4'd3, 32'hDEAD_BEEF);
    chk_port("x5_bypass_p0", 0, 32'hDEAD_BEEF, 1'b0, 4'h0);
    chk_port("x5_bypass_p1", 1, 32'hDEAD_BEEF, 1'b0, 4'h0);
    tick();
    cm_off();
    chk_port("x5_stored", 0, 32'hDEAD_BEEF, 1'b0, 4'h0);

    // rename x7 tag 2; read before the edge still sees old state
    rd(0, 5'd7);
    ds(5'd7, 4'd2);
    chk_port("x7_pre_rename", 0, 32'h0, 1'b0, 4'h0);
    tick();
    idle();
    rd(0, 5'd7);
    chk_port("x7_renamed", 0, 32'h0, 1'b1, 4'd2);
    cm(1, 5'd7, 4'd2, 32'h11);
    chk_port("x7_commit_bypass", 0, 32'h11, 1'b0, 4'h0);
    tick();
    cm_off();
    chk_port("x7_committed", 0, 32'h11, 1'b0, 4'h0);

    // older commit after a newer rename keeps the register busy
    ds(5'd7, 4'd2);
    tick();
    ds(5'd7, 4'd5);
    tick();
    bus.ds_valid = 1'b0;
    cm(0, 5'd7, 4'd2, 32'h22);
    chk_port("x7_stale_bypass", 0, 32'h22, 1'b1, 4'd5);
    tick();
    cm_off();
    chk_port("x7_stale_stored", 0, 32'h22, 1'b1, 4'd5);

    // two ports hit x9; youngest data wins, port 1 tag matches
    ds(5'd9, 4'd4);
    tick();
    bus.ds_valid = 1'b0;
    rd(1, 5'd9);
    cm(0, 5'd9, 4'd1, 32'hAA);
    cm(1, 5'd9, 4'd4, 32'hBB);
    chk_port("x9_dual_bypass", 1, 32'hBB, 1'b0, 4'h0);
    tick();
    cm_off();
    chk_port("x9_dual_stored", 1, 32'hBB, 1'b0, 4'h0);

    // two ports hit x10; port 0 tag matches, port 1 still supplies data
    ds(5'd10, 4'd1);
    tick();
    bus.ds_valid = 1'b0;
    rd(1, 5'd10);
    cm(0, 5'd10, 4'd1, 32'hAA);
    cm(1, 5'd10, 4'd4, 32'hBB);
    tick();
    cm_off();
    chk_port("x10_dual_stored", 1, 32'hBB, 1'b0, 4'h0);

    // dispatch and commit to x3 in the same cycle
    rd(0, 5'd3);
    ds(5'd3, 4'd6);
    cm(0, 5'd3, 4'd1, 32'h33);
    tick();
    idle();
    rd(0, 5'd3);
    chk_port("x3_ds_wins", 0, 32'h33, 1'b1, 4'd6);

    // flush: dispatch to x4 dropped, commit to x11 still written
    bus.flush = 1'b1;
    ds(5'd4, 4'd7);
    cm(1, 5'd11, 4'd0, 32'h44);
    tick();
    idle();
    rd(0, 5'd3);
    rd(1, 5'd7);
    chk_port("flush_x3", 0, 32'h33, 1'b0, 4'h0);
    chk_port("flush_x7", 1, 32'h22, 1'b0, 4'h0);
    rd(0, 5'd4);
    rd(1, 5'd11);
    chk_port("flush_x4", 0, 32'h0, 1'b0, 4'h0);
    chk_port("flush_x11", 1, 32'h44, 1'b0, 4'h0);

    // register 0 ignores commit and dispatch
    idle();
    rd(0, 5'd0);
    cm(0, 5'd0, 4'd0, 32'h55);
    ds(5'd0, 4'd3);
    chk_port("x0_bypass", 0, 32'h0, 1'b0, 4'h0);
    tick();
    idle();
    rd(0, 5'd0);
    chk_port("x0_stored", 0, 32'h0, 1'b0, 4'h0);

    // disabled read port returns zero even for a written register
    bus.rd_en[1]              = 1'b0;
    bus.rd_addr[1*AW +: AW]   = 5'd5;
    chk_port("rd_disabled", 1, 32'h0, 1'b0, 4'h0);

    // asynchronous reset mid-stream
    idle();
    ds(5'd12, 4'd9);
    tick();
    idle();
    rd(0, 5'd12);
    rd(1, 5'd5);
    chk_port("x12_pre_reset", 0, 32'h0, 1'b1, 4'd9);
    cm(0, 5'd5, 4'd1, 32'h66);
    #1;
    rst = 1'b0;
    chk_port("async_rst_p0", 0, 32'h0, 1'b0, 4'h0);
    chk_port("async_rst_p1", 1, 32'h0, 1'b0, 4'h0);
    @(negedge clk);
    cm_off();
    rst = 1'b1;
    tick();
    chk_port("post_rst_x5", 1, 32'h0, 1'b0, 4'h0);
    chk_port("post_rst_x12", 0, 32'h0, 1'b0, 4'h0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_tagged.md
# regfile_tagged

Parametrised architectural register file for the out-of-order core generation. Adds per-register rename state (busy bit plus reorder-buffer tag) to the plain register file. It sits between dispatch, which reads operands and renames the destination, and commit, which retires results. It supports NRD read ports, NCM commit write ports, a dispatch rename port and a global flush. Reads see same-cycle commits through internal bypass.

## Interface
- XLEN, 32, data width
- NREG, 32, register count; AW = $clog2(NREG)
- NRD, 2, read ports
- NCM, 2, commit (write) ports; higher index = younger in program order
- TAGW, 4, ROB tag width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low; clears all registers, busy bits and tags
- rd_en  in  NRD  per-port read enable
- rd_addr  in  NRD*AW  read addresses, port p at [p*AW +: AW]
- rd_data  out  NRD*XLEN  read data
- rd_busy  out  NRD  register awaits an in-flight producer
- rd_tag  out  NRD*TAGW  ROB tag of that producer; valid only when rd_busy
- ds_valid  in  1  dispatch renames a destination this cycle
- ds_addr  in  AW  destination register
- ds_tag  in  TAGW  ROB tag of the dispatched instruction
- cm_valid  in  NCM  commit port valid
- cm_addr  in  NCM*AW  commit destination
- cm_tag  in  NCM*TAGW  tag of the committing instruction
- cm_data  in  NCM*XLEN  commit result
- flush  in  1  pipeline flush (mispredict/exception)

## Operation
- Register 0 reads as 0, is never busy, and ignores commit and dispatch.
- Read port p, combinational:
  - If rd_en[p]=0 or address 0: data=0, busy=0, tag=0.
  - Otherwise data = youngest valid commit to that address this cycle, else the stored value.
  - busy = stored busy AND NOT (a valid commit this cycle carries a matching address and a tag equal to the stored tag).
  - tag = stored tag when busy, else 0.
- Read results reflect state before this cycle's dispatch, so an instruction may read a register it also renames.
- Commit, per valid port with nonzero address:
  - The data is always written.
  - The busy bit clears only if the stored tag equals cm_tag. A newer rename keeps the register busy.
  - When several ports hit the same address, the highest index wins for data. Busy clears if any of those ports matches the tag.
- Dispatch with ds_valid and nonzero address sets busy=1 and tag=ds_tag at the edge.
- If dispatch and commit target the same register in one cycle, dispatch wins busy/tag and commit still writes data.
- Flush clears every busy bit and tag at the edge.
  - Commits in the flush cycle still write data.
  - Dispatch in the flush cycle is dropped.
- There is no FSM. State per register is {data, busy, tag}.

## Timing
- Read latency is 0 cycles (combinational from addresses, stored state and commit inputs).
- Write, rename and flush latency is 1 edge.
- Reset is asynchronous on assertion. After reset, all rd_data=0, rd_busy=0 and rd_tag=0 regardless of enables.
- rst asserted mid-operation discards in-flight busy state immediately. Deassertion is synchronised externally.
- No handshake: all inputs are sampled every edge and there is no backpressure.

## Structure
- The shared defines header holds ZeroWord, ZeroRegAddr, Enable/Disable and a new ZeroTag.
- Sub-module regfile_rd_port: one read-port bypass/busy resolver, instantiated NRD times via generate.
- The top level holds storage, commit priority, and rename/flush update logic.

## Test plan
- Reset then read x5 on both ports -> data 0, busy 0. Commit x5=0xDEADBEEF tag 3 -> same-cycle read returns 0xDEADBEEF, and it is stored next cycle.
- Dispatch x7 tag 2, then read x7 -> busy 1, tag 2. Commit x7 tag 2 data 0x11 -> same-cycle read shows busy 0, data 0x11.
- Dispatch x7 tag 2, dispatch x7 tag 5, commit x7 tag 2 data 0x22 -> x7 data 0x22, still busy with tag 5.
- Commit ports 0 and 1 both write x9 (0xAA tag 1, 0xBB tag 4), stored tag 4 -> x9=0xBB, busy 0.
- Dispatch x3 tag 6 and commit x3 tag 1 data 0x33 in the same cycle -> x3=0x33, busy 1, tag 6. Flush with dispatch x4 -> all busy 0, x4 not renamed.
- Commit/dispatch to x0 -> x0 reads 0, not busy. Assert rst mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
